// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC sine/cosine rotator: state enum,
// quadrant type, gain constant and the arctangent table with its scaling helpers.
package cordic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic [1:0] quad_t;

  // CORDIC gain 1/prod(sqrt(1+2^-2i)) in Q1.31
  localparam logic [31:0] K_Q31 = 32'd1304065747;

  // atan(2^-i) expressed in 2^32-per-turn units
  function automatic logic [31:0] atan_turn32(input int i);
    logic [31:0] t;
    case (i)
      0:  t = 32'h2000_0000;
      1:  t = 32'h12E4_051E;
      2:  t = 32'h09FB_385B;
      3:  t = 32'h0511_11D4;
      4:  t = 32'h028B_0D43;
      5:  t = 32'h0145_D7E1;
      6:  t = 32'h00A2_F61E;
      7:  t = 32'h0051_7C55;
      8:  t = 32'h0028_BE53;
      9:  t = 32'h0014_5F2F;
      10: t = 32'h000A_2F98;
      11: t = 32'h0005_17CC;
      12: t = 32'h0002_8BE6;
      13: t = 32'h0001_45F3;
      14: t = 32'h0000_A2FA;
      15: t = 32'h0000_517D;
      16: t = 32'h0000_28BE;
      17: t = 32'h0000_145F;
      18: t = 32'h0000_0A30;
      19: t = 32'h0000_0518;
      20: t = 32'h0000_028C;
      21: t = 32'h0000_0146;
      22: t = 32'h0000_00A3;
      23: t = 32'h0000_0051;
      24: t = 32'h0000_0029;
      25: t = 32'h0000_0014;
      26: t = 32'h0000_000A;
      27: t = 32'h0000_0005;
      28: t = 32'h0000_0003;
      29: t = 32'h0000_0001;
      30: t = 32'h0000_0001;
      default: t = 32'h0000_0000;
    endcase
    return t;
  endfunction

  // Rescale a table entry to 2^phase_w per turn, rounding to nearest
  function automatic logic [31:0] atan_scaled(input int i, input int phase_w);
    logic [32:0] s;
    s = {1'b0, atan_turn32(i)} + (33'd1 << (31 - phase_w));
    return 32'(s >> (32 - phase_w));
  endfunction

  // Pre-compensated start vector length: round(K * (2^(out_w-1)-1))
  function automatic int cordic_x0(input int out_w);
    logic [63:0] p;
    p = 64'(K_Q31) * ((64'd1 << (out_w - 1)) - 64'd1);
    p = p + 64'h0000_0000_4000_0000;
    return int'(p >> 31);
  endfunction

endpackage

// File: rtl/cordic_sincos_if.sv
// Request/result bundle between the phase source and the CORDIC rotator.
interface cordic_sincos_if #(
  parameter int PHASE_W = 19,
  parameter int OUT_W   = 16
);
  // start is taken on a rising edge only while ready=1 (phase sampled on that
  // edge); valid pulses for one cycle with fresh sin_out/cos_out and is not
  // back-pressured, so the consumer must capture the result in that cycle.
  logic                      start;
  logic [PHASE_W-1:0]        phase;
  logic                      ready;
  logic                      valid;
  logic signed [OUT_W-1:0]   sin_out;
  logic signed [OUT_W-1:0]   cos_out;

  modport master (output start, output phase,
                  input  ready, input valid, input sin_out, input cos_out);
  modport slave  (input  start, input phase,
                  output ready, output valid, output sin_out, output cos_out);
endinterface

// File: rtl/cordic_quad_map.sv
// Combinational quadrant swap/negate, guard-bit removal and symmetric saturation.
// Guard removal rounds half-up when CORDIC_ROUND_EN is defined, else floors.
module cordic_quad_map
  import cordic_pkg::*;
#(
  parameter int OUT_W = 16,
  parameter int GUARD = 2
) (
  input  logic signed [OUT_W+GUARD:0] i_x,
  input  logic signed [OUT_W+GUARD:0] i_y,
  input  quad_t                       i_quad,
  output logic signed [OUT_W-1:0]     o_sin,
  output logic signed [OUT_W-1:0]     o_cos
);

  localparam int XW = OUT_W + GUARD + 1;
  localparam int VW = XW + 1;  // one extra bit so negation cannot wrap
  localparam logic signed [VW-1:0] MAXV = VW'((2 ** (OUT_W - 1)) - 1);

  logic signed [VW-1:0] w_c, w_s, w_cos_g, w_sin_g;

  function automatic logic signed [OUT_W-1:0] drop_sat(input logic signed [VW-1:0] v);
    logic signed [VW-1:0] t;
`ifdef CORDIC_ROUND_EN
    t = (v + VW'(2 ** (GUARD - 1))) >>> GUARD;
`else
    t = v >>> GUARD;
`endif
    if (t > MAXV)       t = MAXV;
    else if (t < -MAXV) t = -MAXV;
    return OUT_W'(t);
  endfunction

  always_comb begin
    w_c = {i_x[XW-1], i_x};
    w_s = {i_y[XW-1], i_y};
    w_cos_g = w_c;
    w_sin_g = w_s;
    case (i_quad)
      2'd0: begin w_cos_g = w_c;  w_sin_g = w_s;  end
      2'd1: begin w_cos_g = -w_s; w_sin_g = w_c;  end
      2'd2: begin w_cos_g = -w_c; w_sin_g = -w_s; end
      default: begin w_cos_g = w_s; w_sin_g = -w_c; end
    endcase
  end

  assign o_cos = drop_sat(w_cos_g);
  assign o_sin = drop_sat(w_sin_g);

endmodule

// File: rtl/cordic_sincos.sv
// Iterative CORDIC rotator: one micro-rotation per clock, ITER+2 cycles per result.
// Optional round-half-up guard removal via CORDIC_ROUND_EN (see cordic_quad_map).
module cordic_sincos
  import cordic_pkg::*;
#(
  parameter int PHASE_W = 19,
  parameter int OUT_W   = 16,
  parameter int ITER    = 16,
  parameter int GUARD   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  cordic_sincos_if.slave    bus,
  output state_e            o_dbg_state
);

  localparam int XW = OUT_W + GUARD + 1;
  localparam int ZW = PHASE_W + 1;
  localparam int IW = $clog2(ITER);
  localparam int X0 = cordic_x0(OUT_W);
  localparam logic signed [XW-1:0] X0_G = XW'(X0 * (2 ** GUARD));

  state_e                   r_state, w_state_next;
  logic signed [XW-1:0]     r_x, r_y;
  logic signed [ZW-1:0]     r_z;
  logic [IW-1:0]            r_i;
  quad_t                    r_quad;
  logic                     r_valid;
  logic signed [OUT_W-1:0]  r_sin, r_cos;

  logic signed [XW-1:0]     w_xs, w_ys;
  logic signed [ZW-1:0]     w_atan;
  logic signed [OUT_W-1:0]  w_sin, w_cos;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_next = ROT;
      ROT:     if (r_i == IW'(ITER - 1)) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign w_xs   = r_x >>> r_i;
  assign w_ys   = r_y >>> r_i;
  assign w_atan = ZW'(atan_scaled(int'(r_i), PHASE_W));

  // Top two phase bits pick the quadrant; the remainder is rotated within [0, pi/2)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_i     <= '0;
      r_quad  <= '0;
      r_valid <= 1'b0;
      r_sin   <= '0;
      r_cos   <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: if (bus.start) begin
          r_quad <= bus.phase[PHASE_W-1 -: 2];
          r_z    <= $signed({3'b000, bus.phase[PHASE_W-3:0]});
          r_x    <= X0_G;
          r_y    <= '0;
          r_i    <= '0;
        end
        ROT: begin
          if (!r_z[ZW-1]) begin
            r_x <= r_x - w_ys;
            r_y <= r_y + w_xs;
            r_z <= r_z - w_atan;
          end else begin
            r_x <= r_x + w_ys;
            r_y <= r_y - w_xs;
            r_z <= r_z + w_atan;
          end
          r_i <= r_i + IW'(1);
        end
        DONE: begin
          r_sin   <= w_sin;
          r_cos   <= w_cos;
          r_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  cordic_quad_map #(
    .OUT_W (OUT_W),
    .GUARD (GUARD)
  ) u_quad_map (
    .i_x    (r_x),
    .i_y    (r_y),
    .i_quad (r_quad),
    .o_sin  (w_sin),
    .o_cos  (w_cos)
  );

  assign bus.ready   = (r_state == IDLE);
  assign bus.valid   = r_valid;
  assign bus.sin_out = r_sin;
  assign bus.cos_out = r_cos;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cordic_sincos.sv
// Bench for cordic_sincos: directed phases, start bursts, mid-rotation reset and
// random phases, all scored against a floating-point sine/cosine model.
module tb_cordic_sincos;
  import cordic_pkg::*;

  localparam int PHASE_W = 19;
  localparam int OUT_W   = 16;
  localparam int ITER    = 16;
  localparam int GUARD   = 2;
  localparam int TOL     = 3;
  localparam int FULL    = 1 << PHASE_W;
  localparam real AMP    = 32767.0;
  localparam real TWO_PI = 6.283185307179586;

  logic   clk = 1'b0;
  logic   rst_n;
  state_e dbg_state;

  cordic_sincos_if #(.PHASE_W(PHASE_W), .OUT_W(OUT_W)) bus ();

  cordic_sincos #(
    .PHASE_W (PHASE_W),
    .OUT_W   (OUT_W),
    .ITER    (ITER),
    .GUARD   (GUARD)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_acc    = 0;
  int n_valid  = 0;

  logic [PHASE_W-1:0] exp_q[$];
  int                 acc_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input int obs, input int exp, input int tol);
    int d;
    n_checks++;
    d = obs - exp;
    if (d < 0) d = -d;
    if (d <= tol) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, exp, tol);
  endtask

  function automatic int rnd(input real r);
    if (r >= 0.0) return $rtoi(r + 0.5);
    return -$rtoi(-r + 0.5);
  endfunction

  // Reference: ideal sine/cosine of the phase, scaled to full scale
  task automatic model(input logic [PHASE_W-1:0] ph, output int c, output int s);
    real a;
    a = TWO_PI * real'(ph) / real'(FULL);
    c = rnd($cos(a) * AMP);
    s = rnd($sin(a) * AMP);
  endtask

  // scoreboard: results in acceptance order, reset discards whatever is in flight
  always @(negedge clk) begin
    logic [PHASE_W-1:0] ph;
    int ac, ec, es, co, so;
    if (bus.valid) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        check_val("spurious_valid", 1, 0, 0);
      end else begin
        ph = exp_q.pop_front();
        ac = acc_cyc_q.pop_front();
        model(ph, ec, es);
        co = int'(bus.cos_out);
        so = int'(bus.sin_out);
        check_val($sformatf("cos@%0d", ph), co, ec, TOL);
        check_val($sformatf("sin@%0d", ph), so, es, TOL);
        check_val("latency", cyc - ac, ITER + 2, 0);
        check_val("ready_with_valid", int'(bus.ready), 1, 0);
        check_val("no_neg_full", int'(co == -32768 || so == -32768), 0, 0);
      end
    end
    if (!rst_n) begin
      exp_q.delete();
      acc_cyc_q.delete();
    end else if (bus.start && bus.ready) begin
      exp_q.push_back(bus.phase);
      acc_cyc_q.push_back(cyc);
      n_acc++;
    end
  end

  // driver tasks
  task automatic start_one(input logic [PHASE_W-1:0] ph);
    int k = 0;
    @(posedge clk); #1;
    while (!bus.ready && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check_val("ready_wait", int'(k < 200), 1, 0);
    bus.start = 1'b1;
    bus.phase = ph;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.phase = PHASE_W'($urandom_range(0, FULL - 1));
  endtask

  task automatic drain();
    int k = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || !bus.ready) && k < 400) begin
      @(negedge clk);
      k++;
    end
    check_val("drain", int'(k < 400), 1, 0);
  endtask

  int dir_ph[10] = '{0, 131072, 262144, 393216, 65536, 458752, 1, 131071, 262143, 524287};

  initial begin
    int a0, v0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.phase = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ready", int'(bus.ready), 1, 0);
    check_val("rst_valid", int'(bus.valid), 0, 0);
    check_val("rst_sin", int'(bus.sin_out), 0, 0);
    check_val("rst_cos", int'(bus.cos_out), 0, 0);
    rst_n = 1'b1;

    // cardinal, diagonal and quadrant-edge phases
    foreach (dir_ph[j]) begin
      start_one(PHASE_W'(dir_ph[j]));
      drain();
    end

    // start held every cycle: only phases seen while ready are taken
    a0 = n_acc;
    v0 = n_valid;
    for (int j = 0; j < 60; j++) begin
      @(posedge clk); #1;
      bus.start = 1'b1;
      bus.phase = PHASE_W'($urandom_range(0, FULL - 1));
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    drain();
    check_val("burst_accepts", n_acc - a0, (60 + ITER + 1) / (ITER + 2), 0);
    check_val("burst_results", n_valid - v0, n_acc - a0, 0);

    // reset during the sixth micro-rotation drops the result
    v0 = n_valid;
    start_one(PHASE_W'($urandom_range(0, FULL - 1)));
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_val("midrst_ready", int'(bus.ready), 1, 0);
    check_val("midrst_sin", int'(bus.sin_out), 0, 0);
    check_val("midrst_cos", int'(bus.cos_out), 0, 0);
    repeat (ITER + 4) @(negedge clk);
    check_val("midrst_no_valid", n_valid - v0, 0, 0);
    start_one(PHASE_W'($urandom_range(0, FULL - 1)));
    drain();

    // random phases
    for (int j = 0; j < 400; j++) begin
      start_one(PHASE_W'($urandom_range(0, FULL - 1)));
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
